// File: rtl/bxf_param_sequencer.sv
// Coefficient sequencer for the balance/crossfeed stage: ramps live Q1.15 coefficients toward handshaked targets.
// Optional feature macro: BXF_RAMP_EN (defined = step limited by RAMP_STEP, undefined = jump at first strobe).
module bxf_param_sequencer #(
  parameter int RAMP_STEP = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic signed [15:0] cfg_balance,
  input  logic        [15:0] cfg_crossfeed,
  input  logic               sample_strobe,
  output logic signed [15:0] balance_q15,
  output logic        [15:0] crossfeed_q15,
  output logic               ramping,
  output logic               done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RAMP = 1'b1;

`ifdef BXF_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  // Without ramping the limit exceeds any possible 17-bit difference, so every step lands on target.
  localparam int                STEP_LIM = RAMP_EN ? RAMP_STEP : 65536;
  localparam logic signed [17:0] LIM     = 18'(STEP_LIM);

  function automatic logic [15:0] step_toward(input logic signed [16:0] cur,
                                              input logic signed [16:0] tgt);
    logic signed [16:0] diff;
    diff = tgt - cur;
    if ($signed({diff[16], diff}) > LIM)
      step_toward = 16'(cur + LIM[16:0]);
    else if ($signed({diff[16], diff}) < -LIM)
      step_toward = 16'(cur - LIM[16:0]);
    else
      step_toward = 16'(tgt);
  endfunction

  function automatic logic signed [15:0] clamp_bal(input logic signed [15:0] v);
    clamp_bal = (v == 16'sh8000) ? 16'sh8001 : v;
  endfunction

  function automatic logic [15:0] clamp_xf(input logic [15:0] v);
    clamp_xf = v[15] ? 16'h7FFF : v;
  endfunction

  logic [0:0]         state_q, state_d;
  logic signed [15:0] bal_q, bal_d, tgt_bal_q, tgt_bal_d;
  logic        [15:0] xf_q, xf_d, tgt_xf_q, tgt_xf_d;
  logic               done_q, done_d;
  logic signed [15:0] bal_nxt;
  logic        [15:0] xf_nxt;

  assign bal_nxt = step_toward({bal_q[15], bal_q}, {tgt_bal_q[15], tgt_bal_q});
  assign xf_nxt  = step_toward({1'b0, xf_q}, {1'b0, tgt_xf_q});

  always_comb begin
    state_d   = state_q;
    bal_d     = bal_q;
    xf_d      = xf_q;
    tgt_bal_d = tgt_bal_q;
    tgt_xf_d  = tgt_xf_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          tgt_bal_d = clamp_bal(cfg_balance);
          tgt_xf_d  = clamp_xf(cfg_crossfeed);
          state_d   = S_RAMP;
        end
      end
      S_RAMP: begin
        // Coefficients only move on strobe edges so each sample sees one stable pair.
        if (sample_strobe) begin
          bal_d = bal_nxt;
          xf_d  = xf_nxt;
          if (bal_nxt == tgt_bal_q && xf_nxt == tgt_xf_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bal_q     <= '0;
      xf_q      <= '0;
      tgt_bal_q <= '0;
      tgt_xf_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bal_q     <= bal_d;
      xf_q      <= xf_d;
      tgt_bal_q <= tgt_bal_d;
      tgt_xf_q  <= tgt_xf_d;
      done_q    <= done_d;
    end
  end

  assign cfg_ready     = (state_q == S_IDLE);
  assign ramping       = (state_q == S_RAMP);
  assign balance_q15   = bal_q;
  assign crossfeed_q15 = xf_q;
  assign done          = done_q;

endmodule

// File: tb/tb_bxf_param_sequencer.sv
// Directed bench for bxf_param_sequencer; expectations follow whether BXF_RAMP_EN is defined.
module tb_bxf_param_sequencer;

`ifdef BXF_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic signed [15:0] cfg_balance = '0;
  logic        [15:0] cfg_crossfeed = '0;
  logic               sample_strobe = 1'b0;
  logic signed [15:0] balance_q15;
  logic        [15:0] crossfeed_q15;
  logic               ramping;
  logic               done;

  int checks = 0;
  int errors = 0;

  bxf_param_sequencer #(.RAMP_STEP(64)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_balance(cfg_balance), .cfg_crossfeed(cfg_crossfeed),
    .sample_strobe(sample_strobe), .balance_q15(balance_q15),
    .crossfeed_q15(crossfeed_q15), .ramping(ramping), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset;
    cfg_valid = 1'b0;
    sample_strobe = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic offer(input logic signed [15:0] b, input logic [15:0] x);
    cfg_balance = b;
    cfg_crossfeed = x;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_strobe;
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if (balance_q15 !== 16'sd0) begin errors++; $display("FAIL reset_bal got %0d exp 0", balance_q15); end
    checks++; if (crossfeed_q15 !== 16'd0) begin errors++; $display("FAIL reset_xf got %0d exp 0", crossfeed_q15); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
    checks++; if (ramping !== 1'b0) begin errors++; $display("FAIL reset_ramping got %b exp 0", ramping); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
  endtask

  task automatic test_basic_ramp;
    int exp_b[4] = '{64, 128, 192, 256};
    int exp_x[4] = '{64, 100, 100, 100};
    int n;
    int eb, ex;
    n = RAMP_EN ? 4 : 1;
    offer(16'sd256, 16'd100);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_ramp got %b exp 0", cfg_ready); end
    checks++; if (ramping !== 1'b1) begin errors++; $display("FAIL basic_ramping got %b exp 1", ramping); end
    for (int i = 0; i < n; i++) begin
      do_strobe();
      eb = RAMP_EN ? exp_b[i] : 256;
      ex = RAMP_EN ? exp_x[i] : 100;
      checks++; if (balance_q15 !== 16'(eb)) begin errors++; $display("FAIL basic_bal[%0d] got %0d exp %0d", i, balance_q15, eb); end
      checks++; if (crossfeed_q15 !== 16'(ex)) begin errors++; $display("FAIL basic_xf[%0d] got %0d exp %0d", i, crossfeed_q15, ex); end
      checks++; if (done !== (i == n - 1)) begin errors++; $display("FAIL basic_done[%0d] got %b exp %b", i, done, (i == n - 1)); end
    end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_end got %b exp 1", cfg_ready); end
    checks++; if (ramping !== 1'b0) begin errors++; $display("FAIL basic_ramping_end got %b exp 0", ramping); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", done); end
  endtask

  task automatic test_idle_strobe;
    do_strobe();
    checks++; if (balance_q15 !== 16'sd256) begin errors++; $display("FAIL idle_bal got %0d exp 256", balance_q15); end
    checks++; if (crossfeed_q15 !== 16'd100) begin errors++; $display("FAIL idle_xf got %0d exp 100", crossfeed_q15); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL idle_done got %b exp 0", done); end
  endtask

  task automatic test_clamp;
    int n;
    int eb, ex;
    apply_reset();
    offer(-16'sd32768, 16'hFFFF);
    do_strobe();
    n = 1;
    eb = RAMP_EN ? -64 : -32767;
    ex = RAMP_EN ? 64 : 32767;
    checks++; if (balance_q15 !== 16'(eb)) begin errors++; $display("FAIL clamp_first_bal got %0d exp %0d", balance_q15, eb); end
    checks++; if (crossfeed_q15 !== 16'(ex)) begin errors++; $display("FAIL clamp_first_xf got %0d exp %0d", crossfeed_q15, ex); end
    while (done !== 1'b1 && n < 600) begin
      do_strobe();
      n++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL clamp_done_timeout got %b exp 1", done); end
    checks++; if (n != (RAMP_EN ? 512 : 1)) begin errors++; $display("FAIL clamp_strobes got %0d exp %0d", n, (RAMP_EN ? 512 : 1)); end
    checks++; if (balance_q15 !== -16'sd32767) begin errors++; $display("FAIL clamp_bal got %0d exp -32767", balance_q15); end
    checks++; if (crossfeed_q15 !== 16'd32767) begin errors++; $display("FAIL clamp_xf got %0d exp 32767", crossfeed_q15); end
  endtask

  task automatic test_stall;
    int exp_b[5] = '{192, 128, 64, 0, -50};
    int n, cnt, eb;
    apply_reset();
    offer(16'sd256, 16'd0);
    cfg_balance = -16'sd50;
    cfg_crossfeed = 16'd0;
    cfg_valid = 1'b1;
    cnt = 0;
    while (done !== 1'b1 && cnt < 10) begin
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0", cnt, cfg_ready); end
      do_strobe();
      cnt++;
    end
    checks++; if (cnt != (RAMP_EN ? 4 : 1)) begin errors++; $display("FAIL stall_first_ramp got %0d exp %0d", cnt, (RAMP_EN ? 4 : 1)); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_at_done got %b exp 1", cfg_ready); end
    checks++; if (balance_q15 !== 16'sd256) begin errors++; $display("FAIL stall_bal_at_done got %0d exp 256", balance_q15); end
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if (ramping !== 1'b1) begin errors++; $display("FAIL stall_transfer got %b exp 1", ramping); end
    n = RAMP_EN ? 5 : 1;
    for (int i = 0; i < n; i++) begin
      do_strobe();
      eb = RAMP_EN ? exp_b[i] : -50;
      checks++; if (balance_q15 !== 16'(eb)) begin errors++; $display("FAIL stall_bal[%0d] got %0d exp %0d", i, balance_q15, eb); end
      checks++; if (done !== (i == n - 1)) begin errors++; $display("FAIL stall_done[%0d] got %b exp %b", i, done, (i == n - 1)); end
    end
  endtask

  task automatic test_coincident_equal;
    int cnt, eb;
    cfg_balance = 16'sd100;
    cfg_crossfeed = 16'd0;
    cfg_valid = 1'b1;
    sample_strobe = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    sample_strobe = 1'b0;
    checks++; if (balance_q15 !== -16'sd50) begin errors++; $display("FAIL coinc_bal got %0d exp -50", balance_q15); end
    checks++; if (ramping !== 1'b1) begin errors++; $display("FAIL coinc_ramping got %b exp 1", ramping); end
    do_strobe();
    eb = RAMP_EN ? 14 : 100;
    checks++; if (balance_q15 !== 16'(eb)) begin errors++; $display("FAIL coinc_first_step got %0d exp %0d", balance_q15, eb); end
    cnt = 0;
    while (done !== 1'b1 && cnt < 10) begin
      do_strobe();
      cnt++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL coinc_done_timeout got %b exp 1", done); end
    checks++; if (balance_q15 !== 16'sd100) begin errors++; $display("FAIL coinc_final got %0d exp 100", balance_q15); end
    offer(16'sd100, 16'd0);
    checks++; if (ramping !== 1'b1) begin errors++; $display("FAIL equal_accept got %b exp 1", ramping); end
    do_strobe();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL equal_done got %b exp 1", done); end
    checks++; if (balance_q15 !== 16'sd100) begin errors++; $display("FAIL equal_bal got %0d exp 100", balance_q15); end
    checks++; if (crossfeed_q15 !== 16'd0) begin errors++; $display("FAIL equal_xf got %0d exp 0", crossfeed_q15); end
  endtask

  task automatic test_reset_mid_ramp;
    int eb;
    apply_reset();
    offer(16'sd256, 16'd0);
    for (int i = 0; i < (RAMP_EN ? 2 : 0); i++) do_strobe();
    eb = RAMP_EN ? 128 : 0;
    checks++; if (balance_q15 !== 16'(eb)) begin errors++; $display("FAIL midrst_pre_bal got %0d exp %0d", balance_q15, eb); end
    rst_n = 1'b0;
    #1;
    checks++; if (balance_q15 !== 16'sd0) begin errors++; $display("FAIL midrst_bal got %0d exp 0", balance_q15); end
    checks++; if (crossfeed_q15 !== 16'd0) begin errors++; $display("FAIL midrst_xf got %0d exp 0", crossfeed_q15); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", cfg_ready); end
    checks++; if (ramping !== 1'b0) begin errors++; $display("FAIL midrst_ramping got %b exp 0", ramping); end
    @(negedge clk);
    rst_n = 1'b1;
    do_strobe();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", done); end
    checks++; if (balance_q15 !== 16'sd0) begin errors++; $display("FAIL midrst_idle_bal got %0d exp 0", balance_q15); end
  endtask

  task automatic test_single_jump;
    int eb;
    apply_reset();
    offer(16'sd20000, 16'd0);
    do_strobe();
    eb = RAMP_EN ? 64 : 20000;
    checks++; if (balance_q15 !== 16'(eb)) begin errors++; $display("FAIL jump_bal got %0d exp %0d", balance_q15, eb); end
    checks++; if (done !== !RAMP_EN) begin errors++; $display("FAIL jump_done got %b exp %b", done, !RAMP_EN); end
    checks++; if (cfg_ready !== !RAMP_EN) begin errors++; $display("FAIL jump_ready got %b exp %b", cfg_ready, !RAMP_EN); end
  endtask

  initial begin
    test_reset();
    test_basic_ramp();
    test_idle_strobe();
    test_clamp();
    test_stall();
    test_coincident_equal();
    test_reset_mid_ramp();
    test_single_jump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bxf_param_sequencer.md
# bxf_param_sequencer

Coefficient sequencer for the balance/crossfeed DSP stage. Accepts new balance and crossfeed targets from the control plane over a valid/ready handshake. Ramps the live coefficients toward those targets by a bounded step per audio sample, so that parameter changes produce no zipper noise or clicks. Its outputs drive the stage's `balance_q15` and `crossfeed_q15` inputs directly, and its `sample_strobe` is the same signal as the stage's `in_valid`.

## Interface
- `RAMP_STEP`, default 64: maximum per-sample change of each coefficient, in Q1.15 LSBs; legal range 1..32767.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_valid`  in  1  new target pair offered.
- `cfg_ready`  out  1  sequencer can accept a target pair.
- `cfg_balance`  in  16 signed  balance target, Q1.15.
- `cfg_crossfeed`  in  16 unsigned  crossfeed target, Q1.15.
- `sample_strobe`  in  1  one-cycle pulse per audio sample (the DSP stage's `in_valid`).
- `balance_q15`  out  16 signed  live balance coefficient.
- `crossfeed_q15`  out  16 unsigned  live crossfeed coefficient.
- `ramping`  out  1  high while a ramp is in progress.
- `done`  out  1  one-cycle pulse when both coefficients reach their targets.

## Operation
- **States:**
  - IDLE: `cfg_ready`=1, `ramping`=0.
  - RAMP: `cfg_ready`=0, `ramping`=1.
- **Reset values:** state IDLE, `balance_q15`=0, `crossfeed_q15`=0, targets=0, `done`=0. `cfg_ready`=1 and `ramping`=0 follow from the IDLE state.
- **Accept:** `cfg_valid && cfg_ready` at a rising edge latches the targets, after clamping, and moves IDLE→RAMP.
- **Target clamping:**
  - Balance: -32768 is clamped to -32767.
  - Crossfeed: values >32767 are clamped to 32767.
- **Stepping (RAMP only):** on each edge with `sample_strobe`=1, each coefficient moves toward its target.
  - Step size is min(`RAMP_STEP`, |target−current|).
  - Differences are computed as 17-bit signed, so no overflow is possible.
- **Completion:** on the stepping edge where both coefficients equal their targets after the update, state goes RAMP→IDLE and `done` is registered high for exactly one cycle.
- **Equal target:** a target pair equal to the current values is still accepted. Completion then occurs at the first strobe in RAMP, with no value change.
- **No preemption:** `cfg_valid` during RAMP is stalled, because `cfg_ready`=0. The master must hold its data until ready.
- **Idle strobes:** `sample_strobe` in IDLE has no effect.

## Timing
- **Handshake:** standard valid/ready. Transfer happens on the edge where both are high. `cfg_ready` is a function of state only and has no combinational path from `cfg_valid`.
- **Acceptance edge:** a `sample_strobe` coincident with the acceptance edge is not applied, since the state was IDLE at that edge. The first step occurs at the next strobe.
- **Output update:** coefficients are registered and change only on the edge that samples `sample_strobe`. They are therefore stable throughout every strobe cycle, and the DSP stage sees one coefficient pair per sample.
- **Ramp latency:** ceil(max(|Δbal|, |Δxf|) / `RAMP_STEP`) strobes in RAMP.
- **Re-acceptance:** `done` and `cfg_ready` rise in the same cycle, so a new pair can be accepted on the next edge.
- **Reset mid-ramp:** the ramp is abandoned immediately, both coefficients return to 0, and no `done` pulse is issued.

## Configuration
- **`BXF_RAMP_EN` defined:** per-sample ramp as described above, limited by `RAMP_STEP`.
- **`BXF_RAMP_EN` undefined:** step size is unlimited. Both coefficients jump to their targets at the first strobe in RAMP, and `done` pulses on that edge. The handshake and all other behaviour are unchanged; `RAMP_STEP` is ignored.

## Test plan
All scenarios use `RAMP_STEP`=64 with `BXF_RAMP_EN` defined unless stated otherwise.
- **Basic ramp:** after reset, offer balance=256, crossfeed=100.
  - Strobes 1..4 give balance 64, 128, 192, 256 and crossfeed 64, 100, 100, 100.
  - `done` pulses after strobe 4.
- **Clamp:** offer balance=-32768, crossfeed=0xFFFF → final values -32767 / 32767 after 512 strobes, then `done`.
- **Stall:** assert `cfg_valid` with balance=-50 while ramping.
  - `cfg_ready` stays 0 until `done`.
  - The transfer occurs on the edge after `done`.
  - Balance then steps down by 64 per strobe until it reaches -50.
- **Coincident strobe and equal target:**
  - A strobe coincident with acceptance produces no change; the first update comes at the next strobe.
  - Re-offering the current values gives `done` at the first RAMP strobe with the coefficients unchanged.
- **Reset mid-ramp:** assert `rst_n`=0 at balance=128 of a ramp to 256 → outputs 0/0, IDLE, `cfg_ready`=1, no `done`.
- **`BXF_RAMP_EN` undefined:** balance 0→20000 completes at a single strobe and `done` pulses on that edge.
